// File: rtl/time_set_writer.sv
// Time/date set controller. It snapshots the live sec..year counters,
// lets the user edit one field at a time, then writes every field back
// over a shared databus with one load strobe per cycle. The order is year,
// mon, day, hour, min, sec.
module time_set_writer #(
  parameter int W            = 6,
  parameter int YEAR_MAX     = 63,
  parameter int EDIT_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         set_mode,
  input  logic         next_field,
  input  logic         inc,
  input  logic         dec,
  input  logic         commit,
  input  logic [W-1:0] cur_sec,
  input  logic [W-1:0] cur_min,
  input  logic [W-1:0] cur_hour,
  input  logic [W-1:0] cur_day,
  input  logic [W-1:0] cur_mon,
  input  logic [W-1:0] cur_year,
  output logic [W-1:0] databus,
  output logic         bus_oe,
  output logic         load_sec,
  output logic         load_min,
  output logic         load_hour,
  output logic         load_day,
  output logic         load_mon,
  output logic         load_year,
  output logic [2:0]   field,
  output logic [W-1:0] edit_val,
  output logic         busy
);

  // Field indices; also the bit positions in the load strobe vector.
  localparam logic [2:0] F_SEC  = 3'd0;
  localparam logic [2:0] F_MIN  = 3'd1;
  localparam logic [2:0] F_HOUR = 3'd2;
  localparam logic [2:0] F_DAY  = 3'd3;
  localparam logic [2:0] F_MON  = 3'd4;
  localparam logic [2:0] F_YEAR = 3'd5;

  // The idle counter only has to reach EDIT_TIMEOUT-1.
  localparam int TW = (EDIT_TIMEOUT > 1) ? $clog2(EDIT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((EDIT_TIMEOUT > 0) ? EDIT_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_e;

  state_e               state_q, state_d;
  logic [2:0]           field_q, field_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [TW-1:0]        to_q, to_d;
  logic [5:0][W-1:0]    val_q, val_d;
  logic [W-1:0]         databus_q, databus_d;
  logic                 bus_oe_q, bus_oe_d;
  logic [5:0]           load_q, load_d;

  logic [W-1:0] snap_sec, snap_min, snap_hour, snap_day, snap_mon, snap_year, snap_md;
  logic [W-1:0] cur_v, new_v, lo, hi, md;
  logic [2:0]   wr_idx;

  // Days in a month; year is an offset from 2000, so year%4==0 is a leap year.
  function automatic logic [W-1:0] max_day(input logic [W-1:0] mon, input logic [W-1:0] year);
    case (mon)
      W'(4), W'(6), W'(9), W'(11): max_day = W'(30);
      W'(2):                       max_day = (year[1:0] == 2'b00) ? W'(29) : W'(28);
      default:                     max_day = W'(31);
    endcase
  endfunction

  // One step up or down inside [lo, hi], wrapping at either end.
  function automatic logic [W-1:0] step_val(input logic [W-1:0] v, input logic [W-1:0] lo_v,
                                            input logic [W-1:0] hi_v, input logic up);
    if (up) step_val = (v >= hi_v) ? lo_v : v + W'(1);
    else    step_val = (v <= lo_v) ? hi_v : v - W'(1);
  endfunction

  // Read one edit register by index without an out-of-range select.
  function automatic logic [W-1:0] pick(input logic [5:0][W-1:0] v, input logic [2:0] idx);
    pick = '0;
    for (int i = 0; i < 6; i++) if (idx == 3'(i)) pick = v[i];
  endfunction

  // Sanitise the live counter values as they would be captured on entry.
  always_comb begin
    snap_sec  = (cur_sec  > W'(59))       ? '0 : cur_sec;
    snap_min  = (cur_min  > W'(59))       ? '0 : cur_min;
    snap_hour = (cur_hour > W'(23))       ? '0 : cur_hour;
    snap_year = (cur_year > W'(YEAR_MAX)) ? '0 : cur_year;
    snap_mon  = (cur_mon == '0 || cur_mon > W'(12)) ? W'(1) : cur_mon;
    snap_md   = max_day(snap_mon, snap_year);
    if (cur_day == '0)          snap_day = W'(1);
    else if (cur_day > snap_md) snap_day = snap_md;
    else                        snap_day = cur_day;
  end

  // Next-state logic for the mode FSM, edit registers and registered bus outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    field_d   = field_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    val_d     = val_q;
    databus_d = '0;
    bus_oe_d  = 1'b0;
    load_d    = '0;
    cur_v     = pick(val_q, field_q);
    lo        = '0;
    hi        = W'(59);
    new_v     = cur_v;
    md        = '0;
    wr_idx    = F_YEAR;

    case (state_q)
      S_IDLE: begin
        if (set_mode) begin
          val_d   = {snap_year, snap_mon, snap_day, snap_hour, snap_min, snap_sec};
          field_d = F_SEC;
          to_d    = '0;
          state_d = S_EDIT;
        end
      end

      S_EDIT: begin
        if (commit) begin
          // Year goes out on the first commit cycle.
          state_d           = S_COMMIT;
          cnt_d             = '0;
          to_d              = '0;
          bus_oe_d          = 1'b1;
          load_d[F_YEAR]    = 1'b1;
          databus_d         = val_q[F_YEAR];
        end else if (set_mode) begin
          state_d = S_IDLE;
          to_d    = '0;
        end else begin
          if (inc ^ dec) begin
            case (field_q)
              F_SEC, F_MIN: begin lo = '0;    hi = W'(59); end
              F_HOUR:       begin lo = '0;    hi = W'(23); end
              F_DAY:        begin lo = W'(1); hi = max_day(val_q[F_MON], val_q[F_YEAR]); end
              F_MON:        begin lo = W'(1); hi = W'(12); end
              default:      begin lo = '0;    hi = W'(YEAR_MAX); end
            endcase
            new_v = step_val(cur_v, lo, hi, inc);
            for (int i = 0; i < 6; i++) if (field_q == 3'(i)) val_d[i] = new_v;
            // A month/year change may shorten the month below the current day.
            if (field_q == F_MON || field_q == F_YEAR) begin
              md = max_day(val_d[F_MON], val_d[F_YEAR]);
              if (val_q[F_DAY] > md) val_d[F_DAY] = md;
            end
          end
          // The edit above used the old field; the pointer advances afterwards.
          if (next_field) field_d = (field_q == F_YEAR) ? F_SEC : field_q + 3'd1;
          if (EDIT_TIMEOUT > 0) begin
            if (next_field || inc || dec) begin
              to_d = '0;
            end else if (to_q == TO_LAST) begin
              to_d    = '0;
              state_d = S_IDLE;
            end else begin
              to_d = to_q + TW'(1);
            end
          end
        end
      end

      S_COMMIT: begin
        if (cnt_q == 3'd5) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          // Step k of the commit writes field 5-k: year, mon, day, hour, min, sec.
          cnt_d          = cnt_q + 3'd1;
          wr_idx         = F_YEAR - cnt_d;
          bus_oe_d       = 1'b1;
          load_d[wr_idx] = 1'b1;
          databus_d      = pick(val_q, wr_idx);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; clear drops the strobes and bus enable asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      field_q   <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      // NOTE: the edit registers are reset as well, because edit_val shows them from reset onward.
      val_q     <= '0;
      databus_q <= '0;
      bus_oe_q  <= 1'b0;
      load_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the same pre-edge values.
      state_q   <= state_d;
      field_q   <= field_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      val_q     <= val_d;
      databus_q <= databus_d;
      bus_oe_q  <= bus_oe_d;
      load_q    <= load_d;
    end
  end

  assign databus   = databus_q;
  assign bus_oe    = bus_oe_q;
  assign load_sec  = load_q[F_SEC];
  assign load_min  = load_q[F_MIN];
  assign load_hour = load_q[F_HOUR];
  assign load_day  = load_q[F_DAY];
  assign load_mon  = load_q[F_MON];
  assign load_year = load_q[F_YEAR];
  assign field     = field_q;
  assign edit_val  = pick(val_q, field_q);
  assign busy      = (state_q != S_IDLE);

endmodule
